// File: rtl/bit_serial_addsub.sv
// ----------------------------------------------------------------------------
// bit_serial_addsub
//
// Bit-serial unsigned adder/subtractor with a start/done handshake. Two
// DWL-bit operands are captured on Start, then one bit per clock is pushed
// through a single full-adder slice (LSB first) with a carry flop. The
// DWL+1-bit result register Sbit is written in one go when the last bit has
// been processed, so it never shows a partially computed value.
//
// Subtraction is In1 + ~In2 + 1: the B operand is inverted at load time and
// the carry flop is preset to 1. For subtraction the top result bit is the
// inverted carry-out, i.e. the borrow (1 iff In1 < In2), which makes Sbit
// the DWL+1-bit two's-complement difference.
//
// Optional feature (macro SIGNED_OVF_EN):
//   When defined, adds output Ovf = signed overflow of the DWL-bit result
//   (carry into the top bit XOR carry out of the top bit), updated together
//   with Sbit. When undefined, the port and its logic do not exist.
//
// Parameters
//   DWL    operand width in bits (>= 2)
//
// Ports
//   CLK    in   1      clock, all state on rising edge
//   RST    in   1      synchronous active-high reset, highest priority
//   Start  in   1      operation request, sampled only while idle
//   Sub    in   1      0 = In1+In2, 1 = In1-In2, sampled with Start
//   In1    in   DWL    operand A (unsigned), sampled with Start
//   In2    in   DWL    operand B (unsigned), sampled with Start
//   Busy   out  1      high while bits are being processed
//   Done   out  1      one-cycle pulse, Sbit has just been updated
//   Sbit   out  DWL+1  result register
//   Ovf    out  1      signed overflow of the result (SIGNED_OVF_EN only)
// ----------------------------------------------------------------------------
module bit_serial_addsub #(
   parameter int DWL = 4
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           Start,
   input  logic           Sub,
   input  logic [DWL-1:0] In1,
   input  logic [DWL-1:0] In2,
   output logic           Busy,
   output logic           Done,
   output logic [DWL:0]   Sbit
`ifdef SIGNED_OVF_EN
   ,
   output logic           Ovf
`endif
);

   localparam int CW = $clog2(DWL + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t state_reg, state_next;

   // Operand A register doubles as the result shift register: each cycle its
   // LSB is consumed by the adder and the new sum bit enters at the MSB, so
   // after DWL shifts it holds the full DWL-bit sum.
   logic [DWL-1:0] a_sr_reg;
   logic [DWL-1:0] b_sr_reg;
   logic           carry_reg;
   logic           op_sub_reg;
   logic [CW-1:0]  count_reg;
   logic           busy_reg;
   logic           done_reg;
   logic [DWL:0]   sbit_reg;
`ifdef SIGNED_OVF_EN
   logic           ovf_reg;
`endif

   // Control strobes decoded by the FSM
   logic load;
   logic shift;
   logic finish;

   // Single full-adder slice
   logic sum_bit;
   logic cout;
   logic last_bit;

   assign sum_bit  = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
   assign cout     = (a_sr_reg[0] & b_sr_reg[0]) |
                     (a_sr_reg[0] & carry_reg)   |
                     (b_sr_reg[0] & carry_reg);
   assign last_bit = (count_reg == CW'(DWL - 1));

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next-state and strobes
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      shift      = 1'b0;
      finish     = 1'b0;
      case (state_reg)
         IDLE: begin
            // Start is also accepted in the Done cycle, since that is IDLE
            if (Start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            // Start is deliberately ignored here: no queueing, no resampling
            shift = 1'b1;
            if (last_bit) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         a_sr_reg   <= '0;
         b_sr_reg   <= '0;
         carry_reg  <= 1'b0;
         op_sub_reg <= 1'b0;
         count_reg  <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         sbit_reg   <= '0;
`ifdef SIGNED_OVF_EN
         ovf_reg    <= 1'b0;
`endif
      end else begin
         done_reg <= finish;
         if (load) begin
            a_sr_reg   <= In1;
            b_sr_reg   <= Sub ? ~In2 : In2;
            carry_reg  <= Sub;
            op_sub_reg <= Sub;
            count_reg  <= '0;
            busy_reg   <= 1'b1;
         end else if (shift) begin
            a_sr_reg  <= {sum_bit, a_sr_reg[DWL-1:1]};
            b_sr_reg  <= {1'b0, b_sr_reg[DWL-1:1]};
            carry_reg <= cout;
            count_reg <= count_reg + CW'(1);
            if (finish) begin
               // Assemble the final bit directly so Sbit updates atomically
               // on the same edge that consumes the last operand bit.
               sbit_reg <= {(op_sub_reg ? ~cout : cout), sum_bit, a_sr_reg[DWL-1:1]};
               busy_reg <= 1'b0;
`ifdef SIGNED_OVF_EN
               // carry_reg is the carry into the top bit at this point
               ovf_reg  <= carry_reg ^ cout;
`endif
            end
         end
      end
   end

   assign Busy = busy_reg;
   assign Done = done_reg;
   assign Sbit = sbit_reg;
`ifdef SIGNED_OVF_EN
   assign Ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_bit_serial_addsub.sv
// ----------------------------------------------------------------------------
// tb_bit_serial_addsub
//
// Directed bench for bit_serial_addsub with DWL = 4. Expected results are
// pushed to a queue when an operation is accepted and popped by a monitor
// whenever Done pulses. Handles SIGNED_OVF_EN when the macro is defined.
// ----------------------------------------------------------------------------
module tb_bit_serial_addsub;

   localparam int DWL = 4;

   logic           CLK;
   logic           RST;
   logic           Start;
   logic           Sub;
   logic [DWL-1:0] In1;
   logic [DWL-1:0] In2;
   logic           Busy;
   logic           Done;
   logic [DWL:0]   Sbit;
`ifdef SIGNED_OVF_EN
   logic           Ovf;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Each entry: {ovf, sbit[DWL:0]}
   logic [DWL+1:0] exp_q[$];

   bit_serial_addsub #(.DWL(DWL)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .Start (Start),
      .Sub   (Sub),
      .In1   (In1),
      .In2   (In2),
      .Busy  (Busy),
      .Done  (Done),
      .Sbit  (Sbit)
`ifdef SIGNED_OVF_EN
      ,
      .Ovf   (Ovf)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reference model: unsigned sum / two's-complement difference, plus the
   // signed overflow of the DWL-bit result.
   function automatic logic [DWL+1:0] model(input logic s, input logic [DWL-1:0] a,
                                            input logic [DWL-1:0] b);
      logic [DWL:0] r;
      int           sa, sb, sr;
      logic         ov;
      sa = (a[DWL-1]) ? int'(a) - (1 << DWL) : int'(a);
      sb = (b[DWL-1]) ? int'(b) - (1 << DWL) : int'(b);
      if (s) begin
         r  = {1'b0, a} - {1'b0, b};
         sr = sa - sb;
      end else begin
         r  = {1'b0, a} + {1'b0, b};
         sr = sa + sb;
      end
      ov = (sr > (1 << (DWL - 1)) - 1) || (sr < -(1 << (DWL - 1)));
      return {ov, r};
   endfunction

   // Drive one request for exactly one edge, pushing its expected result.
   task automatic start_op(input logic s, input logic [DWL-1:0] a, input logic [DWL-1:0] b);
      Start = 1'b1;
      Sub   = s;
      In1   = a;
      In2   = b;
      exp_q.push_back(model(s, a, b));
      $display("op: %s %0d %0d -> expect Sbit %0d", s ? "sub" : "add", a, b,
               model(s, a, b) & {(DWL+1){1'b1}});
      tick();
      Start = 1'b0;
   endtask

   // Wait (bounded) for Done after the Start-sampling edge; check latency.
   task automatic wait_done(input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!Done && n < 20);
      check({tag, "_latency"}, n, DWL);
      check({tag, "_busy_at_done"}, Busy, 0);
   endtask

   // Scoreboard monitor: every Done pulse must match the oldest pending op.
   always @(posedge CLK) begin
      logic [DWL+1:0] e;
      #1;
      if (Done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = exp_q.pop_front();
            $display("done: Sbit=%b expected %b", Sbit, e[DWL:0]);
            check("sbit", Sbit, e[DWL:0]);
`ifdef SIGNED_OVF_EN
            check("ovf", Ovf, e[DWL+1]);
`endif
         end
      end
   end

   initial begin
      RST   = 1'b1;
      Start = 1'b1;          // must be ignored while in reset
      Sub   = 1'b0;
      In1   = 4'b1111;
      In2   = 4'b1111;
      tick();
      tick();
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_sbit", Sbit, 0);
`ifdef SIGNED_OVF_EN
      check("rst_ovf", Ovf, 0);
`endif
      RST   = 1'b0;
      Start = 1'b0;
      tick();
      check("idle_busy", Busy, 0);

      // 1111 + 1111 with explicit cycle-by-cycle handshake checks
      start_op(1'b0, 4'b1111, 4'b1111);
      for (int i = 0; i < DWL - 1; i++) begin
         check("add_busy_high", Busy, 1);
         check("add_done_low", Done, 0);
         tick();
      end
      check("add_busy_last", Busy, 1);
      tick();
      check("add_done_pulse", Done, 1);
      check("add_busy_drop", Busy, 0);
      check("add_sbit", Sbit, 5'b11110);
      tick();
      check("add_done_drop", Done, 0);
      check("add_sbit_hold", Sbit, 5'b11110);

      // Subtractions, including a negative result
      start_op(1'b1, 4'b1110, 4'b0111);
      wait_done("sub_pos");
      check("sub_pos_sbit", Sbit, 5'b00111);
      start_op(1'b1, 4'b0101, 4'b1010);   // accepted in the Done cycle
      wait_done("sub_neg");
      check("sub_neg_sbit", Sbit, 5'b11011);
      tick();

      // 1000 + 1000 with a mid-operation Start on changed operands, then
      // Start held so the next op is taken in the Done cycle.
      start_op(1'b0, 4'b1000, 4'b1000);
      Start = 1'b1;
      Sub   = 1'b1;
      In1   = 4'b0001;
      In2   = 4'b0001;
      tick();
      check("ignore_busy", Busy, 1);
      tick();
      Sub = 1'b0;
      In1 = 4'b0011;
      In2 = 4'b0100;
      exp_q.push_back(model(1'b0, 4'b0011, 4'b0100));
      tick();
      tick();
      check("b2b_first_done", Done, 1);
      check("b2b_first_sbit", Sbit, 5'b10000);
      tick();                              // Done-cycle edge accepts Start
      Start = 1'b0;
      check("b2b_done_drop", Done, 0);
      check("b2b_second_busy", Busy, 1);
      wait_done("b2b_second");             // 5-cycle spacing between Dones
      check("b2b_second_sbit", Sbit, 5'b00111);
      tick();

      // Reset two cycles into an operation aborts it silently
      start_op(1'b0, 4'b1111, 4'b1111);
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      exp_q.delete();
      check("abort_busy", Busy, 0);
      check("abort_done", Done, 0);
      check("abort_sbit", Sbit, 0);
      for (int i = 0; i < DWL + 2; i++) begin
         tick();
         check("abort_no_done", Done, 0);
      end
      start_op(1'b0, 4'b0011, 4'b0001);
      wait_done("after_abort");
      check("after_abort_sbit", Sbit, 5'b00100);
      tick();

      // A handful of random operations through the scoreboard
      for (int i = 0; i < 8; i++) begin
         start_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
         wait_done("rand");
      end
      tick();
      check("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
